// File: rtl/axi_mem_pkg.sv
// axi_mem_pkg: shared burst/response encodings, FSM states and WRAP length check
package axi_mem_pkg;
  typedef enum logic [1:0] {FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10} burst_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_BURST} r_state_t;
  localparam logic [1:0] RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11;
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15;
  endfunction
endpackage

// File: rtl/axi_burst_addr.sv
// axi_burst_addr: byte address, word index, range/last/error flags for beat <step> of a burst
//  in: start, len, size, burst, step; out: idx (RAM word), in_range, last (step==len), err
module axi_burst_addr import axi_mem_pkg::*; #(
  parameter int AW = 32,
  parameter int OFFW = 2,
  parameter int WADDRW = 10,
  parameter int DEPTH = 1024
) (
  input  logic [AW-1:0]     start,
  input  logic [7:0]        len,
  input  logic [2:0]        size,
  input  logic [1:0]        burst,
  input  logic [7:0]        step,
  output logic [WADDRW-1:0] idx,
  output logic              in_range,
  output logic              last,
  output logic              err
);
  logic [AW-1:0] mask, aligned, offs, wmask, addr;
  always_comb begin
    mask = (AW'(1) << size) - AW'(1);
    aligned = start & ~mask;
    offs = AW'(step) << size;
    wmask = ((AW'(len) + AW'(1)) << size) - AW'(1);
    addr = burst == FIXED ? start :
           burst == WRAP  ? (aligned & ~wmask) | ((aligned + offs) & wmask) :
           step == 8'd0   ? start : aligned + offs;
  end
  assign idx = addr[OFFW +: WADDRW];
  assign in_range = (addr >> OFFW) < AW'(DEPTH);
  assign last = step == len;
  assign err = size > 3'(OFFW) || burst == 2'b11 || (burst == WRAP && !wrap_len_ok(len));
endmodule

// File: rtl/blockmem_2p_wrapper.sv
// blockmem_2p_wrapper: simple dual-port RAM, byte-enable write port A, registered read port B
//  A: be_a/addr_a/din_a write; B: en_b/addr_b -> dout_b one cycle later (read-first vs port A)
module blockmem_2p_wrapper #(
  parameter int DW = 32,
  parameter int DEPTH = 1024,
  parameter int AWID = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic [DW/8-1:0] be_a,
  input  logic [AWID-1:0] addr_a,
  input  logic [DW-1:0]   din_a,
  input  logic            en_b,
  input  logic [AWID-1:0] addr_b,
  output logic [DW-1:0]   dout_b
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    for (int i = 0; i < DW/8; i++)
      if (be_a[i]) mem[addr_a][i*8 +: 8] <= din_a[i*8 +: 8];
  always_ff @(posedge clk)
    if (en_b) dout_b <= mem[addr_b];
endmodule

// File: rtl/axi_blk_mem_burst.sv
// axi_blk_mem_burst: AXI4 slave block memory with FIXED/INCR/WRAP bursts, strobes, skid-buffered R
//  s_aclk/s_aresetn: clock, async active-low reset
//  s_axi_aw*/w*/b*: write address, data, response channels
//  s_axi_ar*/r*: read address and data channels
module axi_blk_mem_burst import axi_mem_pkg::*; #(
  parameter int G_DATAWIDTH = 32,
  parameter int G_MEMDEPTH = 1024,
  parameter int G_ID_WIDTH = 4,
  parameter int G_ADDRWIDTH = 32,
  parameter G_INIT_FILE = ""
) (
  input  logic                     s_aclk,
  input  logic                     s_aresetn,
  input  logic [G_ID_WIDTH-1:0]    s_axi_awid,
  input  logic [G_ADDRWIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]               s_axi_awlen,
  input  logic [2:0]               s_axi_awsize,
  input  logic [1:0]               s_axi_awburst,
  input  logic                     s_axi_awvalid,
  output logic                     s_axi_awready,
  input  logic [G_DATAWIDTH-1:0]   s_axi_wdata,
  input  logic [G_DATAWIDTH/8-1:0] s_axi_wstrb,
  input  logic                     s_axi_wlast,
  input  logic                     s_axi_wvalid,
  output logic                     s_axi_wready,
  output logic [G_ID_WIDTH-1:0]    s_axi_bid,
  output logic [1:0]               s_axi_bresp,
  output logic                     s_axi_bvalid,
  input  logic                     s_axi_bready,
  input  logic [G_ID_WIDTH-1:0]    s_axi_arid,
  input  logic [G_ADDRWIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]               s_axi_arlen,
  input  logic [2:0]               s_axi_arsize,
  input  logic [1:0]               s_axi_arburst,
  input  logic                     s_axi_arvalid,
  output logic                     s_axi_arready,
  output logic [G_ID_WIDTH-1:0]    s_axi_rid,
  output logic [G_DATAWIDTH-1:0]   s_axi_rdata,
  output logic [1:0]               s_axi_rresp,
  output logic                     s_axi_rlast,
  output logic                     s_axi_rvalid,
  input  logic                     s_axi_rready
);
  localparam int STRBW = G_DATAWIDTH/8, OFFW = $clog2(STRBW), WADDRW = $clog2(G_MEMDEPTH);
  typedef struct packed {
    logic [G_ID_WIDTH-1:0]  id;
    logic [G_DATAWIDTH-1:0] data;
    logic [1:0]             resp;
    logic                   last;
  } beat_t;
  logic up, aw_hs, w_hs, ar_hs, we, w_in_range, w_last, w_err, r_in_range, r_last, r_err;
  logic issue, inflt, inf_last, push, pop_f, wp, rp;
  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  logic [G_ID_WIDTH-1:0] aw_id, ar_id, inf_id;
  logic [G_ADDRWIDTH-1:0] aw_addr, ar_addr;
  logic [7:0] aw_len, ar_len, wcnt, rcnt;
  logic [2:0] aw_size, ar_size;
  logic [1:0] aw_burst, ar_burst, bresp_q, w_resp, inf_resp, cnt;
  logic [WADDRW-1:0] w_idx, r_idx;
  logic [G_DATAWIDTH-1:0] dout;
  beat_t fifo [2];
  beat_t inf_beat, head;
  axi_burst_addr #(.AW(G_ADDRWIDTH), .OFFW(OFFW), .WADDRW(WADDRW), .DEPTH(G_MEMDEPTH)) u_waddr (
    .start(aw_addr), .len(aw_len), .size(aw_size), .burst(aw_burst), .step(wcnt),
    .idx(w_idx), .in_range(w_in_range), .last(w_last), .err(w_err));
  axi_burst_addr #(.AW(G_ADDRWIDTH), .OFFW(OFFW), .WADDRW(WADDRW), .DEPTH(G_MEMDEPTH)) u_raddr (
    .start(ar_addr), .len(ar_len), .size(ar_size), .burst(ar_burst), .step(rcnt),
    .idx(r_idx), .in_range(r_in_range), .last(r_last), .err(r_err));
  blockmem_2p_wrapper #(.DW(G_DATAWIDTH), .DEPTH(G_MEMDEPTH)) u_ram (
    .clk(s_aclk), .be_a(we ? s_axi_wstrb : '0), .addr_a(w_idx), .din_a(s_axi_wdata),
    .en_b(issue), .addr_b(r_idx), .dout_b(dout));
  assign s_axi_awready = up && w_state == W_IDLE;
  assign s_axi_wready = w_state == W_DATA;
  assign s_axi_bvalid = w_state == W_RESP;
  assign s_axi_bid = aw_id;
  assign s_axi_bresp = bresp_q;
  assign s_axi_arready = up && r_state == R_IDLE;
  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs = s_axi_wvalid && s_axi_wready;
  assign ar_hs = s_axi_arvalid && s_axi_arready;
  assign we = w_hs && w_in_range && !w_err;
  assign w_resp = !w_in_range ? RESP_DECERR :
                  (w_err || s_axi_wlast != w_last) ? RESP_SLVERR : RESP_OKAY;
  // a read is only issued if the skid FIFO can absorb it plus the beat already in the RAM pipe
  assign issue = r_state == R_BURST && (cnt + 2'(inflt)) < 2'd2;
  assign inf_beat = '{id: inf_id, data: inf_resp == RESP_OKAY ? dout : '0, resp: inf_resp, last: inf_last};
  // empty FIFO lets the in-flight beat fall straight through; if not taken it is parked unchanged
  assign head = cnt != 2'd0 ? fifo[rp] : inf_beat;
  assign s_axi_rvalid = cnt != 2'd0 || inflt;
  assign s_axi_rid = head.id;
  assign s_axi_rdata = head.data;
  assign s_axi_rresp = head.resp;
  assign s_axi_rlast = s_axi_rvalid && head.last;
  assign pop_f = s_axi_rready && cnt != 2'd0;
  assign push = inflt && !(cnt == 2'd0 && s_axi_rready);
  always_comb begin
    w_next = w_state;
    r_next = r_state;
    if (w_state == W_IDLE && aw_hs) w_next = W_DATA;
    if (w_state == W_DATA && w_hs && w_last) w_next = W_RESP;
    if (w_state == W_RESP && s_axi_bready) w_next = W_IDLE;
    if (r_state == R_IDLE && ar_hs) r_next = R_BURST;
    if (r_state == R_BURST && issue && r_last) r_next = R_IDLE;
  end
  always_ff @(posedge s_aclk or negedge s_aresetn)
    if (!s_aresetn) begin
      up <= 1'b0;
      w_state <= W_IDLE;
      r_state <= R_IDLE;
      {aw_id, aw_addr, aw_len, aw_size, aw_burst, wcnt, bresp_q} <= '0;
      {ar_id, ar_addr, ar_len, ar_size, ar_burst, rcnt} <= '0;
      {inflt, inf_id, inf_resp, inf_last, cnt, wp, rp} <= '0;
    end else begin
      up <= 1'b1;
      w_state <= w_next;
      r_state <= r_next;
      if (aw_hs) {aw_id, aw_addr, aw_len, aw_size, aw_burst, wcnt, bresp_q} <=
        {s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, 8'd0, RESP_OKAY};
      if (w_hs) begin
        wcnt <= wcnt + 8'd1;
        bresp_q <= w_resp > bresp_q ? w_resp : bresp_q;
      end
      if (ar_hs) {ar_id, ar_addr, ar_len, ar_size, ar_burst, rcnt} <=
        {s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, 8'd0};
      inflt <= issue;
      if (issue) begin
        rcnt <= rcnt + 8'd1;
        inf_id <= ar_id;
        inf_resp <= !r_in_range ? RESP_DECERR : r_err ? RESP_SLVERR : RESP_OKAY;
        inf_last <= r_last;
      end
      if (push) wp <= ~wp;
      if (pop_f) rp <= ~rp;
      cnt <= cnt + 2'(push) - 2'(pop_f);
    end
  always_ff @(posedge s_aclk)
    if (push) fifo[wp] <= inf_beat;
endmodule

// File: tb/tb_axi_blk_mem_burst.sv
// tb_axi_blk_mem_burst: randomized scoreboard bench for axi_blk_mem_burst against a byte-level memory model
module tb_axi_blk_mem_burst;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic [3:0] awid = 0, bid, arid = 0, rid;
  logic [31:0] awaddr = 0, araddr = 0, wdata = 0, rdata;
  logic [7:0] awlen = 0, arlen = 0;
  logic [2:0] awsize = 0, arsize = 0;
  logic [1:0] awburst = 0, arburst = 0, bresp, rresp;
  logic [3:0] wstrb = 0;
  logic awvalid = 0, awready, wlast = 0, wvalid = 0, wready, bvalid, bready = 0;
  logic arvalid = 0, arready, rlast, rvalid, rready = 0;

  axi_blk_mem_burst dut (
    .s_aclk(clk), .s_aresetn(rst_n),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready), .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
    .s_axi_bready(bready), .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
    .s_axi_arsize(arsize), .s_axi_arburst(arburst), .s_axi_arvalid(arvalid),
    .s_axi_arready(arready), .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
    .s_axi_rlast(rlast), .s_axi_rvalid(rvalid), .s_axi_rready(rready));

  typedef struct {logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last;} rexp_t;
  typedef struct {logic [3:0] id; logic [1:0] resp;} bexp_t;
  rexp_t rq[$];
  bexp_t bq[$];
  logic [31:0] mem_m [1024];
  logic [31:0] dq[$];
  logic [3:0] sq[$];
  int checks = 0, failures = 0, rmode = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // reference address of beat i, from the burst rules in plain arithmetic
  function automatic int unsigned m_addr(int unsigned start, int len, int size, int burst, int i);
    int unsigned nb, wsz, base;
    nb = 1 << size;
    if (burst == 0) return start;
    if (burst == 2) begin
      wsz = (len + 1) * nb;
      base = (start / wsz) * wsz;
      return base + ((start - base) + i * nb) % wsz;
    end
    return i == 0 ? start : (start / nb) * nb + i * nb;
  endfunction

  function automatic bit m_err(int len, int size, int burst);
    return size > 2 || burst == 3 || (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
  endfunction

  task automatic hs_wait(input string name, input int which);
    int n = 0;
    forever begin
      @(negedge clk);
      if ((which == 0 && awready) || (which == 1 && wready) || (which == 2 && arready)) break;
      if (++n > 200) begin
        checks++; failures++;
        $display("FAIL %s_timeout actual=no_ready required=ready", name);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [3:0] id, input int unsigned addr, input int len, input int size,
                    input int burst, input logic [31:0] d[$], input logic [3:0] s[$],
                    input bit bad_last = 0, input int abort = -1);
    int nsend;
    int unsigned w;
    logic [1:0] resp;
    nsend = abort >= 0 ? abort : len + 1;
    resp = 0;
    for (int i = 0; i < nsend; i++) begin
      w = m_addr(addr, len, size, burst, i) / 4;
      if (w >= 1024) resp = 3;
      else if (m_err(len, size, burst)) resp = resp < 2 ? 2 : resp;
      else for (int b = 0; b < 4; b++) if (s[i][b]) mem_m[w][b*8 +: 8] = d[i][b*8 +: 8];
    end
    if (bad_last && resp < 2) resp = 2;
    if (abort < 0) bq.push_back('{id, resp});
    awid = id; awaddr = addr; awlen = 8'(len); awsize = 3'(size); awburst = 2'(burst); awvalid = 1;
    hs_wait("aw", 0);
    awvalid = 0;
    for (int i = 0; i < nsend; i++) begin
      wdata = d[i]; wstrb = s[i]; wlast = (i == len) ^ (bad_last && i == 0); wvalid = 1;
      hs_wait("w", 1);
      wvalid = 0;
    end
  endtask

  task automatic rd(input logic [3:0] id, input int unsigned addr, input int len, input int size,
                    input int burst, input bit lat_chk = 0);
    int unsigned w;
    for (int i = 0; i <= len; i++) begin
      w = m_addr(addr, len, size, burst, i) / 4;
      if (w >= 1024) rq.push_back('{id, 32'h0, 2'd3, i == len});
      else if (m_err(len, size, burst)) rq.push_back('{id, 32'h0, 2'd2, i == len});
      else rq.push_back('{id, mem_m[w], 2'd0, i == len});
    end
    arid = id; araddr = addr; arlen = 8'(len); arsize = 3'(size); arburst = 2'(burst); arvalid = 1;
    hs_wait("ar", 2);
    arvalid = 0;
    if (lat_chk) begin
      @(negedge clk); check("r_latency_n1", rvalid, 0);
      @(negedge clk); check("r_latency_n2", rvalid, 1);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((rq.size() != 0 || bq.size() != 0) && n < 3000) begin
      @(posedge clk); n++;
    end
    if (n >= 3000) begin
      checks++; failures++;
      $display("FAIL drain_timeout actual=r%0d/b%0d_pending required=0", rq.size(), bq.size());
      rq.delete(); bq.delete();
    end
    @(posedge clk); #1;
  endtask

  initial forever begin
    @(posedge clk); #1;
    bready = $urandom_range(0, 3) != 0;
  end

  initial forever begin
    @(posedge clk); #1;
    rready = rmode == 0 ? 1'b1 : rmode == 1 ? 1'($urandom_range(0, 1)) : rmode == 2 ? 1'b0 : ~rready;
  end

  initial forever begin
    bexp_t e;
    @(negedge clk);
    if (rst_n && bvalid && bready) begin
      if (bq.size() == 0) begin
        checks++; failures++;
        $display("FAIL b_unexpected actual=id%0d/resp%0d required=none", bid, bresp);
      end else begin
        e = bq.pop_front();
        check("b_id_resp", {bid, bresp}, {e.id, e.resp});
      end
    end
  end

  initial begin
    bit hold = 0;
    logic [39:0] prev = 0;
    rexp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) hold = 0;
      else begin
        if (hold) check("r_stable", {rvalid, rid, rdata, rresp, rlast}, prev);
        if (rvalid && rready) begin
          if (rq.size() == 0) begin
            checks++; failures++;
            $display("FAIL r_unexpected actual=id%0d/data%h required=none", rid, rdata);
          end else begin
            e = rq.pop_front();
            check("r_beat", {rid, rdata, rresp, rlast}, {e.id, e.data, e.resp, e.last});
          end
        end
        hold = rvalid && !rready;
        prev = {rvalid, rid, rdata, rresp, rlast};
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] wl [4];
    int op, burst, size, len;
    int unsigned start;
    wl = '{8'd1, 8'd3, 8'd7, 8'd15};
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {awready, wready, arready}, 0);
    check("rst_valid", {bvalid, rvalid}, 0);
    check("rst_resp", {bresp, rresp, rlast}, 0);
    check("rst_ids", {bid, rid}, 0);
    rst_n = 1;
    @(posedge clk); #1;
    check("ready_after_rst", {awready, arready}, 2'b11);

    dq = {32'hCAFE0000}; sq = {4'hF};
    wr(0, 'h0, 0, 2, 1, dq, sq); drain();
    dq = {32'hDEADBEEF};
    wr(0, 'h10, 0, 2, 1, dq, sq); drain();
    rd(3, 'h10, 0, 2, 1, 1); drain();

    dq = {32'hFFFFFFFF};
    wr(1, 'h20, 0, 2, 1, dq, sq); drain();
    dq = {32'h00000000}; sq = {4'h2};
    wr(1, 'h20, 0, 2, 1, dq, sq); drain();
    rd(2, 'h20, 0, 2, 1); drain();

    dq = {32'd1, 32'd2, 32'd3, 32'd4}; sq = {4'hF, 4'hF, 4'hF, 4'hF};
    wr(4, 'h100, 3, 2, 1, dq, sq); drain();
    rd(5, 'h108, 3, 2, 2); drain();

    dq.delete(); sq.delete();
    for (int i = 0; i < 8; i++) begin dq.push_back($urandom); sq.push_back(4'hF); end
    wr(6, 'h300, 7, 2, 1, dq, sq); drain();
    rmode = 2;
    rd(6, 'h300, 7, 2, 1);
    repeat (5) @(posedge clk);
    rmode = 3;
    drain();
    rmode = 0;

    dq = {32'h11111111}; sq = {4'hF};
    wr(7, 'h1000, 0, 2, 1, dq, sq); drain();
    rd(7, 'h0, 0, 2, 1); drain();
    rd(8, 'h1000, 0, 2, 1); drain();
    dq = {32'h12345678};
    wr(9, 'h10, 0, 2, 3, dq, sq); drain();
    wr(9, 'h10, 0, 3, 1, dq, sq); drain();
    rd(10, 'h10, 0, 2, 1); drain();
    rd(11, 'h100, 1, 2, 3); drain();
    rd(12, 'h100, 2, 2, 2); drain();
    dq = {32'hA5A5A5A5};
    wr(13, 'h40, 0, 2, 1, dq, sq, 1); drain();
    rd(13, 'h40, 0, 2, 1); drain();

    dq = {32'hB0, 32'hB1, 32'hB2, 32'hB3}; sq = {4'hF, 4'hF, 4'hF, 4'hF};
    wr(14, 'h200, 3, 2, 1, dq, sq, 0, 2);
    rst_n = 0;
    #1;
    check("rst_mid_burst", {wready, bvalid, rvalid, awready, arready}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;
    check("ready_after_rst2", {awready, arready}, 2'b11);
    rd(15, 'h200, 1, 2, 1); drain();
    rd(15, 'h100, 3, 2, 1); drain();

    dq.delete(); sq.delete();
    for (int i = 0; i < 256; i++) begin dq.push_back($urandom); sq.push_back(4'hF); end
    wr(1, 'h800, 255, 2, 1, dq, sq); drain();
    rmode = 1;
    for (int t = 0; t < 30; t++) begin
      op = $urandom_range(0, 1);
      burst = $urandom_range(0, 2);
      size = $urandom_range(0, 2);
      len = burst == 2 ? int'(wl[$urandom_range(0, 3)]) : burst == 1 ? $urandom_range(0, 15) : $urandom_range(0, 7);
      start = ('h800 + $urandom_range(0, 'h300)) & ~((32'd1 << size) - 1);
      if (op == 0) begin
        dq.delete(); sq.delete();
        for (int i = 0; i <= len; i++) begin dq.push_back($urandom); sq.push_back(4'($urandom_range(0, 15))); end
        wr(4'($urandom), start, len, size, burst, dq, sq);
      end else rd(4'($urandom), start, len, size, burst);
      drain();
    end
    rmode = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
